// File: rtl/ota_decim_pkg.sv
// Shared types and elaboration-time helpers for the OTA bitstream decimator.
// DECIM_GLITCH_FILTER_EN lengthens the settle interval to cover the filter taps.
package ota_decim_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    ACCUM  = 2'd1,
    DUMP   = 2'd2
  } state_t;

  // Cycles spent in SETTLE so that stale synchroniser/filter contents never reach acc.
  function automatic int settle_len(input int sync_stages);
`ifdef DECIM_GLITCH_FILTER_EN
    return sync_stages + 2;
`else
    return sync_stages;
`endif
  endfunction

  function automatic logic [63:0] sat_max(input int out_w);
    return (64'd1 << out_w) - 64'd1;
  endfunction

endpackage

// File: rtl/ota_bitstream_decimator_sync.sv
// Multi-flop synchroniser for the asynchronous comparator bit, cleared by synchronous active-low reset.
module ota_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/ota_bitstream_decimator.sv
// Accumulate-and-dump ones counter over 2^OSR_LOG2 synchronised comparator samples.
// Optional 3-tap majority glitch filter: define DECIM_GLITCH_FILTER_EN.
module ota_bitstream_decimator
  import ota_decim_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OSR_LOG2    = 8,
  parameter int OUT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmp_in,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic             res_valid,
  output logic             overrun,
  output state_t           fsm_state
);

  // Handshake: a result transfers on any clk edge where res_valid && res_ready;
  // res_data holds steady while res_valid is high and no transfer occurs.

  localparam int                  SET_LEN  = settle_len(SYNC_STAGES);
  localparam logic [2:0]          SET_LAST = 3'(SET_LEN - 1);
  localparam logic [OSR_LOG2-1:0] CNT_LAST = '1;
  localparam logic [63:0]         SAT      = sat_max(OUT_W);

  logic s_sync;
  logic s_bit;

  ota_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (s_sync)
  );

`ifdef DECIM_GLITCH_FILTER_EN
  // Registered taps give two extra cycles of latency and reject single-cycle pulses.
  logic [2:0] taps;

  always_ff @(posedge clk) begin
    if (!rst_n) taps <= '0;
    else        taps <= {taps[1:0], s_sync};
  end

  assign s_bit = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
`else
  assign s_bit = s_sync;
`endif

  state_t              state, state_n;
  logic [OSR_LOG2:0]   acc, acc_n;
  logic [OSR_LOG2-1:0] cnt, cnt_n;
  logic [2:0]          scnt, scnt_n;
  logic [OSR_LOG2:0]   sum;
  logic                load;
  logic [OUT_W-1:0]    res_sat;

  assign sum       = acc + (OSR_LOG2+1)'(s_bit);
  assign res_sat   = (64'(sum) > SAT) ? OUT_W'(SAT) : OUT_W'(sum);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SETTLE;
      acc   <= '0;
      cnt   <= '0;
      scnt  <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      scnt  <= scnt_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    scnt_n  = scnt;
    load    = 1'b0;
    if (!ena) begin
      state_n = SETTLE;
      acc_n   = '0;
      cnt_n   = '0;
      scnt_n  = '0;
    end else begin
      case (state)
        SETTLE: begin
          if (scnt == SET_LAST) begin
            state_n = ACCUM;
            acc_n   = '0;
            cnt_n   = '0;
            scnt_n  = '0;
          end else begin
            scnt_n = scnt + 3'd1;
          end
        end
        ACCUM: begin
          acc_n = sum;
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            load    = 1'b1;
            state_n = DUMP;
          end
        end
        DUMP: begin
          acc_n   = '0;
          cnt_n   = '0;
          state_n = ACCUM;
        end
        default: begin
          state_n = SETTLE;
          acc_n   = '0;
          cnt_n   = '0;
          scnt_n  = '0;
        end
      endcase
    end
  end

  // Single-entry holding register; a drain and a refill may share one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data  <= '0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (load) begin
      if (!res_valid || res_ready) begin
        res_data  <= res_sat;
        res_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// Randomised self-checking bench: two decimators (OSR_LOG2=8 and 4) against a window-level model.
// Honours DECIM_GLITCH_FILTER_EN when the bundle is built with it.
module tb_ota_bitstream_decimator;
  import ota_decim_pkg::*;

  localparam int S  = 2;
`ifdef DECIM_GLITCH_FILTER_EN
  localparam int SL = S + 2;
  localparam int PULSE_EXP = 0;
`else
  localparam int SL = S;
  localparam int PULSE_EXP = 1;
`endif
  localparam int N0 = 256;
  localparam int N1 = 16;

  logic       clk = 1'b0;
  logic       rst_n, ena, cmp_in, res_ready;
  logic [7:0] res_data0, res_data1;
  logic       res_valid0, res_valid1, overrun0, overrun1;
  state_t     fsm0, fsm1;

  int n_chk = 0;
  int n_fail = 0;
  bit run = 0;

  always #5 clk = ~clk;

  ota_bitstream_decimator #(.SYNC_STAGES(S), .OSR_LOG2(8), .OUT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmp_in(cmp_in), .res_ready(res_ready),
    .res_data(res_data0), .res_valid(res_valid0), .overrun(overrun0), .fsm_state(fsm0)
  );

  ota_bitstream_decimator #(.SYNC_STAGES(S), .OSR_LOG2(4), .OUT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmp_in(cmp_in), .res_ready(res_ready),
    .res_data(res_data1), .res_valid(res_valid1), .overrun(overrun1), .fsm_state(fsm1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Window-level reference: ph < SL settling, SL..SL+N-1 sample index, SL+N the discarded dump cycle.
  int         ph [2];
  int         sum [2];
  bit         mv [2];
  int         md [2];
  bit         mov [2];
  int         nwin [2] = '{N0, N1};
  bit         hist [$];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  int         last_hs0 = -1;
  int         last_hs1 = -1;

  function automatic bit model_sbit();
`ifdef DECIM_GLITCH_FILTER_EN
    int ones;
    ones = int'(hist[S]) + int'(hist[S+1]) + int'(hist[S+2]);
    return ones >= 2;
`else
    return hist[S-1];
`endif
  endfunction

  always @(posedge clk) begin
    bit sb, load;
    int res;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ph[i] = 0; sum[i] = 0; mv[i] = 0; md[i] = 0; mov[i] = 0;
      end
      hist.delete();
      for (int j = 0; j < 8; j++) hist.push_back(1'b0);
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      sb = model_sbit();
      for (int i = 0; i < 2; i++) begin
        load = 0;
        res = 0;
        if (mv[i] && res_ready) begin
          if (i == 0) begin
            if (exp_q0.size() > 0) chk("sb_data0", res_data0, exp_q0.pop_front());
            last_hs0 = res_data0;
          end else begin
            if (exp_q1.size() > 0) chk("sb_data1", res_data1, exp_q1.pop_front());
            last_hs1 = res_data1;
          end
        end
        if (!ena) begin
          ph[i] = 0;
          sum[i] = 0;
        end else if (ph[i] < SL) begin
          ph[i]++;
          sum[i] = 0;
        end else if (ph[i] < SL + nwin[i]) begin
          sum[i] += int'(sb);
          if (ph[i] == SL + nwin[i] - 1) begin
            load = 1;
            res = (sum[i] > 255) ? 255 : sum[i];
          end
          ph[i]++;
        end else begin
          ph[i] = SL;
          sum[i] = 0;
        end
        if (load) begin
          if (!mv[i] || res_ready) begin
            mv[i] = 1;
            md[i] = res;
            if (i == 0) exp_q0.push_back(8'(res));
            else        exp_q1.push_back(8'(res));
          end else begin
            mov[i] = 1;
          end
        end else if (mv[i] && res_ready) begin
          mv[i] = 0;
        end
      end
      hist.push_front(cmp_in);
      void'(hist.pop_back());
    end
  end

  int cyc = 0;
  int rise1 = -1;
  int period1 = 0;
  bit prev_v1 = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (run) begin
      chk("valid0", res_valid0, mv[0]);
      chk("data0", res_data0, md[0]);
      chk("ovr0", overrun0, mov[0]);
      chk("valid1", res_valid1, mv[1]);
      chk("data1", res_data1, md[1]);
      chk("ovr1", overrun1, mov[1]);
      if (res_valid1 && !prev_v1) begin
        if (rise1 >= 0) period1 = cyc - rise1;
        rise1 = cyc;
      end
      prev_v1 = res_valid1;
    end
  end

  task automatic wait_ph(input int target);
    int k;
    for (k = 0; k < 1000; k++) begin
      if (ph[0] == target) break;
      @(negedge clk);
    end
    if (k == 1000) chk("wait_ph_timeout", 32'(k), 0);
  endtask

  task automatic wait_valid0();
    int k;
    for (k = 0; k < 1000; k++) begin
      if (res_valid0) break;
      @(negedge clk);
    end
    if (k == 1000) chk("wait_valid_timeout", 32'(k), 0);
  endtask

  initial begin
    int n;
    logic [7:0] held;
    rst_n = 1'b0; ena = 1'b0; cmp_in = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    run = 1;
    chk("rst_valid", res_valid0, 0);
    chk("rst_data", res_data0, 0);
    chk("rst_ovr", overrun0, 0);
    chk("rst_state", 32'(fsm0), 32'(SETTLE));
    rst_n = 1'b1;

    // Constant ones: saturating full window.
    ena = 1'b1; cmp_in = 1'b1; res_ready = 1'b1;
    repeat (3 * 257 + 20) @(negedge clk);
    chk("t1_data_sat", 32'(last_hs0), 255);
    chk("t1_ovr", overrun0, 0);
    chk("t1_data_small", 32'(last_hs1), 16);

    // Alternating input: half-count, 17-cycle period on the short window.
    for (int i = 0; i < 3 * 257 + 20; i++) begin
      cmp_in = ~cmp_in;
      @(negedge clk);
    end
    chk("t2_data0", 32'(last_hs0), 128);
    chk("t2_data1", 32'(last_hs1), 8);
    chk("t2_period1", 32'(period1), 17);

    // Drain and refill on the same edge.
    res_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cmp_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    wait_valid0();
    wait_ph(SL + N0 - 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("t4_valid", res_valid0, 1);
    chk("t4_ovr", overrun0, 0);

    // Unconsumed results: hold first, flag overrun after the next window.
    wait_valid0();
    held = res_data0;
    for (int i = 0; i < 2 * 257 + 10; i++) begin
      cmp_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("t3_hold", res_data0, held);
    chk("t3_ovr", overrun0, 1);
    while (ph[0] == SL + N0 - 1) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    chk("t3_clear", res_valid0, 0);

    // Abort a window with ena, then measure restart latency counting the ena cycle as 1.
    repeat (100) begin
      cmp_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ena = 1'b0;
    repeat (40) @(negedge clk);
    cmp_in = 1'b1;
    ena = 1'b1;
    n = 1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      n++;
      if (res_valid0) break;
    end
    chk("t5_latency", 32'(n), 32'(SL + 257));
    chk("t5_data", res_data0, 255);

    // Single-cycle pulse each window.
    cmp_in = 1'b0;
    for (int w = 0; w < 3; w++) begin
      wait_ph(SL + 100);
      cmp_in = 1'b1;
      @(negedge clk);
      cmp_in = 1'b0;
    end
    wait_ph(SL + N0);
    wait_ph(SL + 5);
    chk("t6_pulse", 32'(last_hs0), 32'(PULSE_EXP));

    // Reset mid-window with a pending result.
    res_ready = 1'b0;
    cmp_in = 1'b1;
    wait_valid0();
    wait_ph(SL + 50);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", res_valid0, 0);
    chk("rst_mid_data", res_data0, 0);
    chk("rst_mid_ovr", overrun0, 0);
    chk("rst_mid_state", 32'(fsm0), 32'(SETTLE));
    rst_n = 1'b1;

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      ena       = ($urandom_range(0, 199) != 0);
      cmp_in    = 1'($urandom_range(0, 1));
      res_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
